matmul_sched: RTL and testbench
===============================

# matmul_sched

Two-requester round-robin scheduler for the shared 4x4 8-bit matrix-multiply core. Accepts operand pairs over valid/ready from two requesters (e.g. the control core and the DVFS-managed host port), drives one job at a time into the combinational multiplier, and returns the 16-bit-per-element result to the owning requester over valid/ready. It sits between the requesters and the single multiplier instance, so the core is time-shared rather than duplicated.

## Interface
- LATENCY, default 2: settle cycles between operand launch and result capture; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents a job.
- req_ready  out  2  bit i: job from requester i accepted this cycle.
- req_a0, req_b0  in  128 each  requester 0 operands; element (r,c) at bits [(r*4+c)*8 +: 8].
- req_a1, req_b1  in  128 each  requester 1 operands, same packing.
- rsp_valid  out  2  bit i: result for requester i is on rsp_data.
- rsp_ready  in  2  bit i: requester i takes the result.
- rsp_data  out  256  result; element (r,c) at bits [(r*4+c)*16 +: 16].
- core_a, core_b  out  128 each  registered operands to the multiplier.
- core_c  in  256  multiplier result, combinational from core_a/core_b.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  requester owning the current/last job.

## Operation
- States: IDLE, COMPUTE, RESP.
- IDLE: sel = requester with req_valid set; if both set, sel = prio (round-robin pointer). req_ready[sel] = 1 combinationally, only in IDLE, only for sel, only if req_valid[sel]; never both bits.
- Accept (req_valid[sel] & req_ready[sel] at edge): core_a/core_b <= sel's operands, grant_id <= sel, cnt <= LATENCY-1, state <= COMPUTE.
- COMPUTE: if cnt == 0, rsp_data <= core_c, rsp_valid[grant_id] <= 1, state <= RESP; else cnt <= cnt-1.
- RESP: hold rsp_valid and rsp_data until rsp_ready[grant_id]; at that edge rsp_valid <= 0, prio <= ~grant_id, state <= IDLE. rsp_ready of the other bit ignored.
- No arithmetic in this block; rsp_data is core_c verbatim (16-bit per-element wrap done by the core).
- core_a/core_b and rsp_data hold their values after completion until the next accept/capture.

## Timing
- Reset values: state IDLE, prio 0, req_ready 0 (IDLE with no valids), rsp_valid 0, rsp_data 0, core_a 0, core_b 0, busy 0, grant_id 0, cnt 0.
- Accept edge E: rsp_valid rises at edge E+LATENCY; earliest next accept at the edge after the rsp handshake (no IDLE bypass), so minimum job period LATENCY+2 cycles with rsp_ready held high.
- Requests arriving while busy wait; req_ready stays 0. Requesters must hold req_valid and operands until accepted.
- Both valid in IDLE: prio wins; loser served next job if still valid (no starvation).
- rsp_ready low in RESP: stall indefinitely, outputs stable.
- rst mid-COMPUTE or mid-RESP: next cycle all outputs at reset values, job dropped, no response issued, prio 0.
- busy: 1 from the cycle after accept through the cycle of the rsp handshake.

## Test plan
- Identity x B: req 0 sends A = identity (0x01 on diagonal), B element (r,c) = r*4+c, rsp_ready=1 -> rsp_valid[0] exactly LATENCY clocks after accept, rsp_data element (r,c) = 0x00(r*4+c).
- Saturation wrap: all A,B = 0xFF -> every element 0xF804 (4*0xFE01 mod 2^16).
- Contention: after reset both req_valid held with distinct jobs -> requester 0 served first, then requester 1; third job from 0 while 1 still valid -> 1 wins next round.
- Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_data/rsp_valid stable, req_ready=0 despite req_valid[1]=1; accept of 1 on the cycle after rsp handshake.
- Reset mid-COMPUTE (LATENCY=3, rst 1 cycle after accept) -> no rsp_valid ever for that job, all outputs zero, next job completes normally.
- LATENCY=1 back-to-back with rsp_ready=1 -> accepts every 3 cycles, busy pattern 1,1,0 repeating.

Source files
------------

// File: rtl/matmul_sched.sv
// Round-robin scheduler that time-shares one combinational 4x4 8-bit matmul core between two requesters.
// Latency: result valid LATENCY cycles after the accept edge; minimum job period LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE for the selected requester; RESP holds results until rsp_ready of the owner.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0] per-requester job handshake; operands req_a0/req_b0, req_a1/req_b1 (8b elements)
//   rsp_valid/rsp_ready[1:0] per-requester result handshake; rsp_data carries 16 x 16b elements
//   core_a/core_b/core_c     registered operands out to the multiplier, its combinational result back
//   busy, grant_id           not IDLE; requester owning the current/last job
module matmul_sched #(
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_a0,
    input  logic [127:0] req_b0,
    input  logic [127:0] req_a1,
    input  logic [127:0] req_b1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [255:0] rsp_data,
    output logic [127:0] core_a,
    output logic [127:0] core_b,
    input  logic [255:0] core_c,
    output logic         busy,
    output logic         grant_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t       state_q,     state_d;
    logic         prio_q,      prio_d;
    logic         grant_q,     grant_d;
    logic [3:0]   cnt_q,       cnt_d;
    logic [127:0] core_a_q,    core_a_d;
    logic [127:0] core_b_q,    core_b_d;
    logic [255:0] rsp_data_q,  rsp_data_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic         sel;

    always_comb begin
        // A lone requester wins outright; the round-robin pointer only breaks ties.
        sel = prio_q;
        if (req_valid == 2'b01) begin
            sel = 1'b0;
        end else if (req_valid == 2'b10) begin
            sel = 1'b1;
        end

        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;

        case (state_q)
            IDLE: begin
                if (req_valid[sel]) begin
                    req_ready[sel] = 1'b1;
                    core_a_d       = sel ? req_a1 : req_a0;
                    core_b_d       = sel ? req_b1 : req_b0;
                    grant_d        = sel;
                    cnt_d          = CNT_INIT;
                    state_d        = COMPUTE;
                end
            end
            COMPUTE: begin
                // cnt counts the remaining settle cycles of the combinational core.
                if (cnt_q == 4'd0) begin
                    rsp_data_d           = core_c;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~grant_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            cnt_q       <= 4'd0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: scoreboard of expected results per requester, checked by a separate monitor.
// Latency: n/a (testbench).
// Backpressure: drives random and directed rsp_ready stalls.
module tb_matmul_sched;

    localparam int LAT = 2;
    localparam int P   = LAT + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a0, req_b0, req_a1, req_b1, core_a, core_b;
    logic [255:0] rsp_data, core_c;
    logic         busy, grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [255:0] exp_q0[$];
    logic [255:0] exp_q1[$];
    int           acc_log[$];
    int           acc_cyc[2];
    logic [1:0]   vld_prev;
    logic [1:0]   acc, rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference 4x4 product with 16-bit element wrap; also serves as the multiplier core.
    function automatic logic [255:0] mm(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] res;
        logic [15:0]  s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 16'd0;
                for (int k = 0; k < 4; k++)
                    s = s + 16'(a[(r*4+k)*8 +: 8]) * 16'(b[(k*4+c)*8 +: 8]);
                res[(r*4+c)*16 +: 16] = s;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign core_c = mm(core_a, core_b);

    matmul_sched #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, expv);
        end
    endtask

    // Monitor: scoreboard pops, latency, ownership and handshake invariants.
    initial begin
        vld_prev = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                vld_prev = 2'b00;
            end else begin
                chk("rdy_both", {255'b0, req_ready == 2'b11}, '0);
                chk("rdy_no_vld", {254'b0, req_ready & ~req_valid}, '0);
                chk("rsp_vld_both", {255'b0, rsp_valid == 2'b11}, '0);
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        acc_cyc[i] = cyc + 1;
                        acc_log.push_back(i);
                    end
                    if (rsp_valid[i] && !vld_prev[i]) begin
                        chk("rsp_latency", cyc - acc_cyc[i], LAT);
                        chk("rsp_owner", {255'b0, grant_id}, i);
                    end
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        if (i == 0) begin
                            if (exp_q0.size() == 0) chk("unexpected_rsp0", 1, 0);
                            else chk("rsp_data0", rsp_data, exp_q0.pop_front());
                        end else begin
                            if (exp_q1.size() == 0) chk("unexpected_rsp1", 1, 0);
                            else chk("rsp_data1", rsp_data, exp_q1.pop_front());
                        end
                    end
                end
                vld_prev = rsp_valid;
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; handshakes are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        acc = req_valid & req_ready;
        rd  = rsp_valid & rsp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [127:0] a, input logic [127:0] b,
                         input logic [255:0] e, input bit push);
        if (i == 0) begin
            req_a0 = a; req_b0 = b;
            if (push) exp_q0.push_back(e);
        end else begin
            req_a1 = a; req_b1 = b;
            if (push) exp_q1.push_back(e);
        end
        req_valid[i] = 1'b1;
    endtask

    task automatic issue_rnd(input int i, input bit push);
        logic [127:0] a, b;
        a = rnd128();
        b = rnd128();
        issue(i, a, b, mm(a, b), push);
    endtask

    task automatic wait_acc(input int i, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!acc[i] && n < 100);
        chk(name, {255'b0, acc[i]}, 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || rsp_valid != 2'b00) && n < 100) begin
            step();
            n++;
        end
        chk(name, {255'b0, busy}, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {254'b0, req_ready}, '0);
        chk({tag, "_rsp_valid"}, {254'b0, rsp_valid}, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_core_a"}, {128'b0, core_a}, '0);
        chk({tag, "_core_b"}, {128'b0, core_b}, '0);
        chk({tag, "_busy"}, {255'b0, busy}, '0);
        chk({tag, "_grant_id"}, {255'b0, grant_id}, '0);
    endtask

    initial begin
        logic [127:0] a, b;
        logic [255:0] e, held;
        int           n, t, nacc, first_t, last_t;
        bit           third_sent;

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Identity x B: result equals B, elements r*4+c widened to 16 bits.
        a = '0; b = '0; e = '0;
        for (int r = 0; r < 4; r++) begin
            a[(r*4+r)*8 +: 8] = 8'h01;
            for (int c = 0; c < 4; c++) begin
                b[(r*4+c)*8 +: 8]  = 8'(r*4+c);
                e[(r*4+c)*16 +: 16] = 16'(r*4+c);
            end
        end
        rsp_ready = 2'b11;
        issue(0, a, b, e, 1);
        wait_acc(0, "ident_acc");
        wait_idle("ident_idle");

        // Saturation: every element 4*0xFE01 mod 2^16.
        a = '1;
        b = '1;
        issue(0, a, b, {16{16'hF804}}, 1);
        wait_acc(0, "sat_acc");
        wait_idle("sat_idle");

        // Contention from reset: 0 first, then 1, then 0 again.
        rst = 1'b1; step(); rst = 1'b0;
        acc_log.delete();
        issue_rnd(0, 1);
        issue_rnd(1, 1);
        third_sent = 1'b0;
        n = 0;
        while (acc_log.size() < 3 && n < 100) begin
            step();
            n++;
            if (acc[0] && !third_sent) begin
                issue_rnd(0, 1);
                third_sent = 1'b1;
            end else if (acc[0]) begin
                req_valid[0] = 1'b0;
            end
            if (acc[1]) req_valid[1] = 1'b0;
        end
        chk("cont_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("cont_first", acc_log[0], 0);
            chk("cont_second", acc_log[1], 1);
            chk("cont_third", acc_log[2], 0);
        end
        req_valid = 2'b00;
        wait_idle("cont_idle");

        // Backpressure: hold RESP for 5 cycles with requester 1 waiting.
        rsp_ready = 2'b00;
        issue_rnd(0, 1);
        wait_acc(0, "bp_acc0");
        issue_rnd(1, 1);
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
            step();
            n++;
        end
        chk("bp_rsp_rise", {254'b0, rsp_valid}, 2'b01);
        held = rsp_data;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_vld_hold", {254'b0, rsp_valid}, 2'b01);
            chk("bp_data_hold", rsp_data, held);
            chk("bp_no_ready", {254'b0, req_ready}, '0);
        end
        rsp_ready = 2'b11;
        step();
        chk("bp_handshake", {254'b0, rd}, 2'b01);
        step();
        chk("bp_accept_1", {254'b0, acc}, 2'b10);
        req_valid[1] = 1'b0;
        wait_idle("bp_idle");

        // Reset one cycle after accept: job dropped, no response.
        issue_rnd(0, 0);
        wait_acc(0, "rst_acc");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        repeat (2 * P) step();
        chk("midrst_no_rsp", {254'b0, rsp_valid}, '0);
        issue_rnd(0, 1);
        wait_acc(0, "midrst_next_acc");
        wait_idle("midrst_idle");

        // Back-to-back from one requester: accept every P cycles, busy 1 for P-1 cycles then 0.
        nacc = 0; first_t = 0; last_t = 0; t = 0;
        issue_rnd(0, 1);
        while (t < 80 && !(nacc == 3 && t == first_t + 3*P - 1)) begin
            step();
            t++;
            if (acc[0]) begin
                nacc++;
                if (nacc == 1) first_t = t;
                else chk("b2b_interval", t - last_t, P);
                last_t = t;
                if (nacc < 3) issue_rnd(0, 1);
                else req_valid[0] = 1'b0;
            end
            if (nacc > 0)
                chk("b2b_busy", {255'b0, busy}, {255'b0, ((t - first_t) % P) != P - 1});
        end
        chk("b2b_count", nacc, 3);
        wait_idle("b2b_idle");

        // Random traffic with random response backpressure.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) issue_rnd(i, 1);
            rsp_ready = 2'($urandom);
            step();
            for (int i = 0; i < 2; i++)
                if (acc[i]) req_valid[i] = 1'b0;
        end
        rsp_ready = 2'b11;
        n = 0;
        while ((req_valid != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            step();
            n++;
            for (int i = 0; i < 2; i++)
                if (acc[i]) req_valid[i] = 1'b0;
        end
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
